// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES owner encoding, width constants and GF(2^8)
//                S-box helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

   typedef enum logic {
      OWNER_DATA = 1'b0,
      OWNER_KEY  = 1'b1
   } owner_e;

   localparam int c_aes_state_width = 128;
   localparam int c_aes_word_width  = 32;

   function automatic logic [7:0] gf_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = gf_xtime(x);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse, with 0 mapping to 0
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] sq;
      r  = 8'h01;
      sq = a;
      for (int k = 1; k < 8; k++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

endpackage
`default_nettype wire

// File: rtl/subbyte_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : subbyte_arbiter_if
//  Description : Request/response handshakes between the round datapath,
//                key expansion and the shared S-box arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface subbyte_arbiter_if #(
   parameter int DATA_WIDTH = aes_pkg::c_aes_state_width,
   parameter int WORD_WIDTH = aes_pkg::c_aes_word_width
);
   logic                  data_req_valid;
   logic [DATA_WIDTH-1:0] data_req_in;
   logic                  data_req_ready;
   logic                  key_req_valid;
   logic [WORD_WIDTH-1:0] key_req_in;
   logic                  key_req_ready;
   logic                  data_rsp_valid;
   logic [DATA_WIDTH-1:0] data_rsp_out;
   logic                  data_rsp_ready;
   logic                  key_rsp_valid;
   logic [WORD_WIDTH-1:0] key_rsp_out;
   logic                  key_rsp_ready;

   modport master (
      output data_req_valid, data_req_in, key_req_valid, key_req_in,
      output data_rsp_ready, key_rsp_ready,
      input  data_req_ready, key_req_ready,
      input  data_rsp_valid, data_rsp_out, key_rsp_valid, key_rsp_out
   );

   modport slave (
      input  data_req_valid, data_req_in, key_req_valid, key_req_in,
      input  data_rsp_ready, key_rsp_ready,
      output data_req_ready, key_req_ready,
      output data_rsp_valid, data_rsp_out, key_rsp_valid, key_rsp_out
   );
endinterface
`default_nettype wire

// File: rtl/subByte.sv
`default_nettype none
// ============================================================================
//  Module      : subByte
//  Description : Combinational byte-wise AES S-box over a DATA_WIDTH vector,
//                either table based or computed from GF(2^8) arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module subByte #(
   parameter int DATA_WIDTH     = aes_pkg::c_aes_state_width,
   parameter int ROM_WIDTH      = 20,
   parameter int SELECT_SUBBYTE = 0
) (
   input  wire logic                  subByte_valid_in,
   input  wire logic [DATA_WIDTH-1:0] subByte_data_in,
   output logic      [DATA_WIDTH-1:0] subByte_data_out
);
   import aes_pkg::*;

   // Entry 0 sits in the top byte, so entry n lives at bit (255-n)*8
   localparam logic [2047:0] c_sbox = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   for (genvar i = 0; i < DATA_WIDTH/8; i++) begin : g_byte
      logic [7:0] w_in;
      logic [7:0] w_sub;
      assign w_in = subByte_data_in[8*i +: 8];

      if (SELECT_SUBBYTE == 1 && ROM_WIDTH >= 8) begin : g_lut
         assign w_sub = c_sbox[{~w_in, 3'b000} +: 8];
      end else begin : g_logic
         assign w_sub = sbox_calc(w_in);
      end

      assign subByte_data_out[8*i +: 8] = subByte_valid_in ? w_sub : 8'h00;
   end
endmodule
`default_nettype wire

// File: rtl/subbyte_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : subbyte_arbiter
//  Description : Round-robin sharing of one subByte bank between the round
//                datapath and key expansion, with a registered result stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module subbyte_arbiter #(
   parameter int DATA_WIDTH     = aes_pkg::c_aes_state_width,
   parameter int WORD_WIDTH     = aes_pkg::c_aes_word_width,
   parameter int SELECT_SUBBYTE = 0,
   parameter int ROM_WIDTH      = 20
) (
   input wire logic          clk,
   input wire logic          rst,
   subbyte_arbiter_if.slave  bus
);
   import aes_pkg::*;

   logic                  r_out_valid;
   owner_e                r_out_owner;
   logic [DATA_WIDTH-1:0] r_out_data;
   owner_e                r_last_grant;

   logic                  w_owner_ready;
   logic                  w_stage_free;
   logic                  w_grant_data;
   logic                  w_grant_key;
   logic [DATA_WIDTH-1:0] w_key_ext;
   logic [DATA_WIDTH-1:0] w_sbox_in;
   logic [DATA_WIDTH-1:0] w_sbox_out;

   // The stage refills in the same cycle its current owner drains it
   assign w_owner_ready = (r_out_owner == OWNER_DATA) ? bus.data_rsp_ready : bus.key_rsp_ready;
   assign w_stage_free  = !r_out_valid || w_owner_ready;

   assign w_grant_data = w_stage_free && bus.data_req_valid &&
                         (!bus.key_req_valid || r_last_grant == OWNER_KEY);
   assign w_grant_key  = w_stage_free && bus.key_req_valid &&
                         (!bus.data_req_valid || r_last_grant == OWNER_DATA);

   assign bus.data_req_ready = w_grant_data;
   assign bus.key_req_ready  = w_grant_key;

   always_comb begin
      w_key_ext                 = '0;
      w_key_ext[WORD_WIDTH-1:0] = bus.key_req_in;
   end

   assign w_sbox_in = w_grant_key ? w_key_ext : bus.data_req_in;

   subByte #(
      .DATA_WIDTH     (DATA_WIDTH),
      .ROM_WIDTH      (ROM_WIDTH),
      .SELECT_SUBBYTE (SELECT_SUBBYTE)
   ) u_subbyte (
      .subByte_valid_in (1'b1),
      .subByte_data_in  (w_sbox_in),
      .subByte_data_out (w_sbox_out)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_valid  <= 1'b0;
         r_out_owner  <= OWNER_DATA;
         r_out_data   <= '0;
         r_last_grant <= OWNER_KEY;
      end else if (w_grant_data || w_grant_key) begin
         r_out_valid  <= 1'b1;
         r_out_owner  <= w_grant_key ? OWNER_KEY : OWNER_DATA;
         r_out_data   <= w_sbox_out;
         r_last_grant <= w_grant_key ? OWNER_KEY : OWNER_DATA;
      end else if (w_owner_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign bus.data_rsp_valid = r_out_valid && (r_out_owner == OWNER_DATA);
   assign bus.data_rsp_out   = r_out_data;
   assign bus.key_rsp_valid  = r_out_valid && (r_out_owner == OWNER_KEY);
   assign bus.key_rsp_out    = r_out_data[WORD_WIDTH-1:0];
endmodule
`default_nettype wire

// File: doc/subbyte_arbiter.md
# subbyte_arbiter

Shares one `subByte` S-box datapath between two requesters: the round datapath, which substitutes a 128-bit state, and key expansion, which substitutes a 32-bit SubWord. Arbitration is round-robin and each requester has a valid/ready handshake. A single registered output stage returns each result to its owner under a response valid/ready handshake. The block sits between the round controller, the key-expansion unit and the shared `subByte` instance, so the design needs only one S-box bank.

## Interface
Parameters:
- `DATA_WIDTH`, 128, state width; must be a multiple of 8.
- `WORD_WIDTH`, 32, key-expansion word width; must be ≤ `DATA_WIDTH` and a multiple of 8.
- `SELECT_SUBBYTE`, 0, passed to `subByte`; 1 selects the LUT, 0 selects combinational logic.
- `ROM_WIDTH`, 20, passed to `subByte`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `data_req_valid`  in  1  round datapath presents a state.
- `data_req_in`  in  DATA_WIDTH  state to substitute.
- `data_req_ready`  out  1  state accepted this cycle.
- `key_req_valid`  in  1  key expansion presents a word.
- `key_req_in`  in  WORD_WIDTH  word to substitute.
- `key_req_ready`  out  1  word accepted this cycle.
- `data_rsp_valid`  out  1  substituted state is available.
- `data_rsp_out`  out  DATA_WIDTH  substituted state.
- `data_rsp_ready`  in  1  round datapath consumes the response.
- `key_rsp_valid`  out  1  substituted word is available.
- `key_rsp_out`  out  WORD_WIDTH  substituted word.
- `key_rsp_ready`  in  1  key expansion consumes the response.

## Operation
- **Output stage.** Internal registers: `out_valid`, `out_owner` (DATA or KEY), `out_data[DATA_WIDTH-1:0]`, `last_grant` (DATA or KEY).
- **Stage free.** `stage_free = !out_valid || (out_owner==DATA ? data_rsp_ready : key_rsp_ready)`. The stage can accept a new request in the same cycle it drains.
- **Grant rules** (evaluated only when `stage_free`):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester other than `last_grant` is granted.
  - Not `stage_free`: no grant.
- **Ready.** `data_req_ready` = grant to DATA; `key_req_ready` = grant to KEY. Both are combinational from valid, `out_valid`, `out_owner`, the rsp_ready signals and `last_grant`. At most one is high in any cycle.
- **S-box input mux.**
  - DATA grant: `data_req_in` drives `subByte`.
  - KEY grant: `key_req_in` is zero-extended into the low `WORD_WIDTH` bits; the upper bytes are 0 and their results are discarded.
- **`subByte` connection.** `subByte_valid_in` is tied to 1; the substituted result is always used.
- **On a grant edge:** `out_valid`←1, `out_owner`←granted requester, `out_data`←`subByte` output, `last_grant`←granted requester.
- **On a drain without a new grant:** `out_valid`←0; `out_data` holds its value.
- **Response outputs.**
  - `data_rsp_valid = out_valid && out_owner==DATA`; `data_rsp_out = out_data`.
  - `key_rsp_valid = out_valid && out_owner==KEY`; `key_rsp_out = out_data[WORD_WIDTH-1:0]`.
- **Stability.** Once a response is valid, `out_data` and `out_owner` stay stable until it is consumed.
- **Requester rules.** A requester must hold its valid and data stable until ready. Valid dropped without ready is not an error; the request is simply not taken.

## Timing
- **Reset values:** `out_valid`=0, `out_owner`=DATA, `out_data`=0, `last_grant`=KEY, so DATA wins the first tie. All rsp_valid outputs are 0 and all rsp outputs are 0.
- **Latency:** a request accepted at edge N shows its response valid from just after edge N (1 cycle).
- **Throughput:** one result per cycle when the owner holds rsp_ready high.
- **Back-pressure:** while the owner's rsp_ready is low, both req_ready outputs are 0, including for the non-owner.
- **Ties:** sustained simultaneous requests alternate DATA, KEY, DATA, … with no starvation. The worst-case wait is 1 grant.
- **Reset mid-operation:** asserting `rst` clears the output stage immediately. The in-flight response is lost and requesters re-issue after release.

## Structure
- **Shared package `aes_pkg`:** owner encoding (DATA=0, KEY=1) and the AES width constants, 128 and 32.
- **One sub-module:** a single instance of the existing `subByte`, with `DATA_WIDTH`, `ROM_WIDTH` and `SELECT_SUBBYTE` passed through.
- **Arbiter logic:** the grant, mux and output-register logic lives in `subbyte_arbiter` itself.

## Test plan
- **Reset:** release reset with no requests → all rsp_valid=0 and all rsp outputs=0.
- **DATA request:** DATA request `128'h00112233445566778899aabbccddeeff` with `data_rsp_ready`=1 → one cycle later `data_rsp_out`=`128'h638293c31bfc33f5c4eeacea4bc12816` and `data_rsp_valid`=1 for exactly 1 cycle.
- **KEY request:** KEY request `32'hcf4f3c09` → `key_rsp_out`=`32'h8a84eb01`; `data_rsp_valid` stays 0.
- **Tie:** both valid continuously for 4 cycles after reset, both rsp_ready=1 → grant order DATA, KEY, DATA, KEY with correct owner-routed results.
- **Back-pressure:** DATA response held with `data_rsp_ready`=0 for 3 cycles while KEY is valid → `key_req_ready`=0 and `data_rsp_out` is stable throughout. KEY is granted in the cycle `data_rsp_ready` rises.
- **Reset mid-flight:** assert `rst` while `key_rsp_valid`=1 → it drops immediately with no clock edge. After release the next tie grants DATA first.
